timestamp_merger: RTL and testbench

Downstream of `sample_discriminator`: merges its per-channel timestamp stream into one AXI-Stream for the DMA/PS path. Each timestamp beat is tagged with its source channel index. Each channel has a small FIFO, and the FIFOs are drained by a round-robin arbiter. The input side is realtime with no backpressure, so overflow is detected, flagged per channel and counted.

---
 rtl/timestamp_merger.sv | 195 +++++++++++++++++++
 tb/tb_timestamp_merger.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_merger.sv
// timestamp_merger
// Merges per-channel timestamp words from the discriminator into a single
// AXI-Stream. Each channel has its own FIFO. A round-robin arbiter drains
// the FIFOs into a single output register, and each beat is tagged with its
// channel index. The input side cannot be stalled, so a word that arrives
// at a full FIFO is dropped, flagged in `overflow` and counted.
//
// Optional feature: define TIMESTAMP_MERGER_DROP_COUNT_EN to build the
// 32-bit saturating drop counter. When it is undefined, drop_count is
// tied to 0.
//
// Output handshake (AXI-Stream): a beat transfers on a rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// out_data and out_valid hold steady. out_valid never waits for out_ready.
module timestamp_merger #(
    parameter int CHANNELS   = 8,
    parameter int TS_WIDTH   = 64,
    parameter int FIFO_DEPTH = 16,
    localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         adc_clk,
    input  logic                         adc_reset_n,
    input  logic [CHANNELS*TS_WIDTH-1:0] ts_in_data,
    input  logic [CHANNELS-1:0]          ts_in_valid,
    output logic [CH_BITS+TS_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS-1:0]          overflow,
    output logic [31:0]                  drop_count,
    input  logic                         clear_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // Per-channel FIFO storage and pointers. The pointer MSB is a wrap
    // bit that tells "full" apart from "empty".
    logic [TS_WIDTH-1:0] mem [CHANNELS][FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr [CHANNELS];
    logic [PW-1:0]       rd_ptr [CHANNELS];

    logic [CHANNELS-1:0] fifo_empty;
    logic [CHANNELS-1:0] fifo_full;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] drop;

    logic                load;
    logic                found;
    logic [CH_BITS-1:0]  grant;
    logic [CH_BITS-1:0]  last_grant;
    logic [TS_WIDTH-1:0] head;

    // FIFO status: empty when the pointers match. Full when the wrap bits
    // differ and the address bits match.
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
            fifo_full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                            (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
        end
    end

    // Round-robin search. It starts at the channel after the last grant,
    // and the first non-empty FIFO wins.
    always_comb begin
        int           idx;
        logic [CH_BITS-1:0] idx_b;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_b = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx   = (int'(last_grant) + 1 + i) % CHANNELS;
            idx_b = CH_BITS'(idx);
            if (!found && !fifo_empty[idx_b]) begin
                found = 1'b1;
                grant = idx_b;
            end
        end
    end

    // Head word of the granted FIFO; this value is loaded into the output
    // register.
    always_comb begin
        head = mem[grant][rd_ptr[grant][AW-1:0]];
    end

    // Pop, write-accept and drop decisions. A full FIFO that is popped in
    // the same cycle still accepts the incoming word.
    always_comb begin
        load  = !out_valid || out_ready;
        pop   = '0;
        wr_en = '0;
        drop  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pop[c]   = load && found && (grant == CH_BITS'(c));
            wr_en[c] = ts_in_valid[c] && (!fifo_full[c] || pop[c]);
            drop[c]  = ts_in_valid[c] && fifo_full[c] && !pop[c];
        end
    end

    // FIFO pointer registers. On reset every queue is emptied.
    always_ff @(posedge adc_clk) begin
        if (!adc_reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (pop[c])   rd_ptr[c] <= rd_ptr[c] + PW'(1);
            end
        end
    end

    // FIFO storage write. The data array needs no reset because the
    // pointers decide what is valid.
    always_ff @(posedge adc_clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en[c]) begin
                mem[c][wr_ptr[c][AW-1:0]] <= ts_in_data[c*TS_WIDTH +: TS_WIDTH];
            end
        end
    end

    // Output register and arbiter history. The register reloads whenever
    // it is empty or its beat is accepted. When no FIFO has data, out_valid
    // drops.
    always_ff @(posedge adc_clk) begin
        if (!adc_reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_grant <= CH_BITS'(CHANNELS - 1);
        end else if (load) begin
            if (found) begin
                out_valid  <= 1'b1;
                out_data   <= {grant, head};
                last_grant <= grant;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

    // Sticky per-channel overflow flags. A drop in the same cycle as a
    // clear takes priority, so the flags for that cycle's drops stay set.
    always_ff @(posedge adc_clk) begin
        if (!adc_reset_n) begin
            overflow <= '0;
        end else if (clear_overflow) begin
            overflow <= drop;
        end else begin
            overflow <= overflow | drop;
        end
    end

`ifdef TIMESTAMP_MERGER_DROP_COUNT_EN
    logic [31:0] drop_inc;
    logic [32:0] drop_sum;
    logic [31:0] drop_cnt;

    // Number of channels dropping this cycle, and the saturating running
    // total.
    always_comb begin
        drop_inc = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            drop_inc = drop_inc + {31'b0, drop[c]};
        end
        drop_sum = {1'b0, drop_cnt} + {1'b0, drop_inc};
    end

    // Drop counter. A clear restarts it from this cycle's drops, and it
    // saturates at all-ones.
    always_ff @(posedge adc_clk) begin
        if (!adc_reset_n) begin
            drop_cnt <= '0;
        end else if (clear_overflow) begin
            drop_cnt <= drop_inc;
        end else if (drop_sum[32]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[31:0];
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_timestamp_merger.sv
// Testbench for timestamp_merger with the default parameters: 8 channels,
// 64-bit timestamps and 16-entry FIFOs. It uses directed scenarios, and
// each task checks its own expected values.
module tb_timestamp_merger;

    localparam int CHANNELS   = 8;
    localparam int TS_WIDTH   = 64;
    localparam int FIFO_DEPTH = 16;
    localparam int CH_BITS    = 3;
    localparam int OW         = CH_BITS + TS_WIDTH;

`ifdef TIMESTAMP_MERGER_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic                         adc_clk;
    logic                         adc_reset_n;
    logic [CHANNELS*TS_WIDTH-1:0] ts_in_data;
    logic [CHANNELS-1:0]          ts_in_valid;
    logic [OW-1:0]                out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHANNELS-1:0]          overflow;
    logic [31:0]                  drop_count;
    logic                         clear_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    timestamp_merger #(
        .CHANNELS   (CHANNELS),
        .TS_WIDTH   (TS_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .adc_clk        (adc_clk),
        .adc_reset_n    (adc_reset_n),
        .ts_in_data     (ts_in_data),
        .ts_in_valid    (ts_in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    // Clock and reset
    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic idle_inputs();
        ts_in_valid    = '0;
        ts_in_data     = '0;
        clear_overflow = 1'b0;
    endtask

    task automatic do_reset();
        adc_reset_n = 1'b0;
        out_ready   = 1'b0;
        idle_inputs();
        tick();
        adc_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        adc_reset_n = 1'b0;
        out_ready   = 1'b0;
        idle_inputs();
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        tests_run++;
        if (out_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        tests_run++;
        if (overflow !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_overflow: got %h expected 00", overflow);
        end
        tests_run++;
        if (drop_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_drop_count: got %0d expected 0", drop_count);
        end
        adc_reset_n = 1'b1;
    endtask

    task automatic test_single_channel();
        do_reset();
        out_ready = 1'b1;
        ts_in_valid[3] = 1'b1;
        ts_in_data[3*TS_WIDTH +: TS_WIDTH] = 64'h1234;
        tick();
        idle_inputs();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early_valid: got %0b expected 0", out_valid);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== {3'd3, 64'h1234}) begin
            tests_failed++;
            $display("FAIL single_beat: got valid=%0b data=%h expected valid=1 data=%h",
                     out_valid, out_data, {3'd3, 64'h1234});
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after_valid: got %0b expected 0", out_valid);
        end
        tests_run++;
        if (overflow !== 8'h00) begin
            tests_failed++;
            $display("FAIL single_overflow: got %h expected 00", overflow);
        end
    endtask

    task automatic test_round_robin();
        logic [OW-1:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            ts_in_valid[c] = 1'b1;
            ts_in_data[c*TS_WIDTH +: TS_WIDTH] = TS_WIDTH'(c);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < CHANNELS; c++) begin
            tick();
            exp = {CH_BITS'(c), TS_WIDTH'(c)};
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                tests_failed++;
                $display("FAIL rr_beat%0d: got valid=%0b data=%h expected valid=1 data=%h",
                         c, out_valid, out_data, exp);
            end
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_end_valid: got %0b expected 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [OW-1:0] exp;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ts_in_valid[5] = 1'b1;
            ts_in_data[5*TS_WIDTH +: TS_WIDTH] = 64'h100 + 64'(i);
            tick();
        end
        idle_inputs();
        tests_run++;
        if (overflow !== 8'h20) begin
            tests_failed++;
            $display("FAIL ovf_flags: got %h expected 20", overflow);
        end
        tests_run++;
        if (drop_count !== (DC_EN ? 32'd1 : 32'd0)) begin
            tests_failed++;
            $display("FAIL ovf_drop_count: got %0d expected %0d", drop_count, DC_EN ? 1 : 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            exp = {3'd5, 64'h100 + 64'(i)};
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                tests_failed++;
                $display("FAIL ovf_drain%0d: got valid=%0b data=%h expected valid=1 data=%h",
                         i, out_valid, out_data, exp);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_drain_end: got valid=%0b expected 0", out_valid);
        end
        tests_run++;
        if (overflow !== 8'h20) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %h expected 20", overflow);
        end
    endtask

    task automatic test_clear_collision();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ts_in_valid[1] = 1'b1;
            ts_in_valid[2] = 1'b1;
            ts_in_data[1*TS_WIDTH +: TS_WIDTH] = 64'h1000 + 64'(i);
            ts_in_data[2*TS_WIDTH +: TS_WIDTH] = 64'h2000 + 64'(i);
            tick();
            if (i == 16) begin
                tests_run++;
                if (drop_count !== (DC_EN ? 32'd1 : 32'd0)) begin
                    tests_failed++;
                    $display("FAIL clr_count_single: got %0d expected %0d", drop_count, DC_EN ? 1 : 0);
                end
            end
            if (i == 17) begin
                tests_run++;
                if (drop_count !== (DC_EN ? 32'd3 : 32'd0)) begin
                    tests_failed++;
                    $display("FAIL clr_count_popcount: got %0d expected %0d", drop_count, DC_EN ? 3 : 0);
                end
            end
        end
        idle_inputs();
        ts_in_valid[2] = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (drop_count !== (DC_EN ? 32'd4 : 32'd0) || overflow !== 8'h06) begin
            tests_failed++;
            $display("FAIL clr_before: got count=%0d ovf=%h expected count=%0d ovf=06",
                     drop_count, overflow, DC_EN ? 4 : 0);
        end
        ts_in_valid[2] = 1'b1;
        clear_overflow = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (drop_count !== (DC_EN ? 32'd1 : 32'd0)) begin
            tests_failed++;
            $display("FAIL clr_collision_count: got %0d expected %0d", drop_count, DC_EN ? 1 : 0);
        end
        tests_run++;
        if (overflow !== 8'h04) begin
            tests_failed++;
            $display("FAIL clr_collision_flags: got %h expected 04", overflow);
        end
        clear_overflow = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (drop_count !== 32'd0 || overflow !== 8'h00) begin
            tests_failed++;
            $display("FAIL clr_plain: got count=%0d ovf=%h expected count=0 ovf=00",
                     drop_count, overflow);
        end
    endtask

    // Scoreboard: one expected queue per channel
    logic [TS_WIDTH-1:0] exp_q [CHANNELS][$];

    task automatic test_backpressure();
        int            traffic [3] = '{0, 4, 7};
        int            seq;
        int            ch;
        logic          stalled;
        logic          ready;
        logic [OW-1:0] held;
        logic [TS_WIDTH-1:0] word;
        do_reset();
        for (int c = 0; c < CHANNELS; c++) exp_q[c].delete();
        seq     = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (stalled) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    tests_failed++;
                    $display("FAIL bp_hold: got valid=%0b data=%h expected valid=1 data=%h",
                             out_valid, out_data, held);
                end
            end
            ready = ($urandom_range(0, 3) != 0);
            out_ready = ready;
            if (out_valid && ready) begin
                ch = int'(out_data[OW-1:TS_WIDTH]);
                tests_run++;
                if (exp_q[ch].size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_order: got unexpected beat %h expected none on channel %0d",
                             out_data, ch);
                end else begin
                    word = exp_q[ch].pop_front();
                    if (out_data[TS_WIDTH-1:0] !== word) begin
                        tests_failed++;
                        $display("FAIL bp_order: got %h expected %h on channel %0d",
                                 out_data[TS_WIDTH-1:0], word, ch);
                    end
                end
            end
            stalled = out_valid && !ready;
            held    = out_data;
            idle_inputs();
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    seq++;
                    word = TS_WIDTH'(seq) | (TS_WIDTH'(traffic[k]) << 32);
                    ts_in_valid[traffic[k]] = 1'b1;
                    ts_in_data[traffic[k]*TS_WIDTH +: TS_WIDTH] = word;
                    exp_q[traffic[k]].push_back(word);
                end
            end
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (out_valid) begin
                ch = int'(out_data[OW-1:TS_WIDTH]);
                tests_run++;
                if (exp_q[ch].size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_drain: got unexpected beat %h expected none on channel %0d",
                             out_data, ch);
                end else begin
                    word = exp_q[ch].pop_front();
                    if (out_data[TS_WIDTH-1:0] !== word) begin
                        tests_failed++;
                        $display("FAIL bp_drain: got %h expected %h on channel %0d",
                                 out_data[TS_WIDTH-1:0], word, ch);
                    end
                end
            end
            tick();
        end
        for (int c = 0; c < CHANNELS; c++) begin
            tests_run++;
            if (exp_q[c].size() != 0) begin
                tests_failed++;
                $display("FAIL bp_leftover: got %0d words left on channel %0d expected 0",
                         exp_q[c].size(), c);
            end
        end
        tests_run++;
        if (overflow !== 8'h00) begin
            tests_failed++;
            $display("FAIL bp_overflow: got %h expected 00", overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 5; c++) begin
                ts_in_valid[c] = 1'b1;
                ts_in_data[c*TS_WIDTH +: TS_WIDTH] = 64'hA000 + 64'(c * 2 + i);
            end
            tick();
        end
        idle_inputs();
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre_reset: got valid=%0b expected 1", out_valid);
        end
        adc_reset_n = 1'b0;
        tick();
        adc_reset_n = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got valid=%0b data=%h expected valid=0 data=0",
                     out_valid, out_data);
        end
        out_ready = 1'b1;
        ts_in_valid[6] = 1'b1;
        ts_in_data[6*TS_WIDTH +: TS_WIDTH] = 64'h66;
        tick();
        idle_inputs();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_early: got valid=%0b expected 0", out_valid);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== {3'd6, 64'h66}) begin
            tests_failed++;
            $display("FAIL mid_first_beat: got valid=%0b data=%h expected valid=1 data=%h",
                     out_valid, out_data, {3'd6, 64'h66});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_no_stale: got valid=%0b data=%h expected valid=0",
                         out_valid, out_data);
            end
        end
    endtask

    // Test sequence and final report
    initial begin
        adc_reset_n = 1'b0;
        out_ready   = 1'b0;
        idle_inputs();
        test_reset();
        test_single_channel();
        test_round_robin();
        test_overflow();
        test_clear_collision();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
